// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, parity constants and width helper
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_ERROR  = 3'd5
   } rx_state_t;

   function automatic int sampleWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchroniser, start-edge detect, oversample counter and bit sampler
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around the bit centre instead of a single sample.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int Oversample = 16
) (
   input  logic clk,
   input  logic nReset,
   input  logic en,
   input  logic in,
   input  logic clear,
   output logic fallEdge,
   output logic sampleStrobe,
   output logic bitVal,
   output logic wrapStrobe
);

   localparam int CW = sampleWidth(Oversample);
   localparam logic [CW-1:0] HALF = CW'(Oversample / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(Oversample - 1);

   logic [1:0]    syncReg;
   logic          s;
   logic          sPrev;
   logic [CW-1:0] sampleCount;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) syncReg <= 2'b11;
      else         syncReg <= {syncReg[0], in};
   end

   assign s = syncReg[1];

   // Edge history only advances on ticks so a low between ticks is judged at tick resolution.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sPrev       <= 1'b1;
         sampleCount <= '0;
      end else if (en) begin
         sPrev       <= s;
         sampleCount <= clear ? '0 : sampleCount + CW'(1);
      end
   end

   assign fallEdge   = en && sPrev && !s;
   assign wrapStrobe = en && (sampleCount == LAST);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] HALF_M1 = CW'(Oversample / 2 - 2);
   localparam logic [CW-1:0] HALF_P1 = CW'(Oversample / 2);

   logic [1:0] hist;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         hist <= 2'b11;
      end else if (en) begin
         if (sampleCount == HALF_M1) hist[0] <= s;
         if (sampleCount == HALF)    hist[1] <= s;
      end
   end

   assign sampleStrobe = en && (sampleCount == HALF_P1);
   assign bitVal       = (hist[0] & hist[1]) | (hist[0] & s) | (hist[1] & s);
`else
   assign sampleStrobe = en && (sampleCount == HALF);
   assign bitVal       = s;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling UART receiver with parity/stop checks and valid/ready output
// Optional UART_RX_MAJORITY_EN: majority-voted bit sampling (one extra tick of latency).
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int      Oversample = 16,
   parameter int      DataBits   = 8,
   parameter parity_t Parity     = PARITY_NONE,
   parameter int      StopBits   = 1
) (
   input  logic                clk,
   input  logic                nReset,
   input  logic                en,
   input  logic                in,
   output logic [DataBits-1:0] data,
   output logic                valid,
   input  logic                ready,
   output logic                parityErr,
   output logic                frameErr,
   output logic                overrun,
   output logic                busy
);

   localparam int BW = sampleWidth(DataBits + 1);

   rx_state_t           state;
   logic [DataBits-1:0] shiftReg;
   logic [BW-1:0]       bitCount;
   logic                stopCount;
   logic                parityBad;
   logic                fallEdge;
   logic                sampleStrobe;
   logic                bitVal;
   logic                wrapStrobe;
   logic                lastStop;
   logic                done;

   uart_rx_sampler #(.Oversample(Oversample)) sampler (
      .clk         (clk),
      .nReset      (nReset),
      .en          (en),
      .in          (in),
      .clear       (state == RX_IDLE),
      .fallEdge    (fallEdge),
      .sampleStrobe(sampleStrobe),
      .bitVal      (bitVal),
      .wrapStrobe  (wrapStrobe)
   );

   assign lastStop = (stopCount == 1'(StopBits - 1));
   assign done     = sampleStrobe && (state == RX_STOP) && bitVal && lastStop;
   assign busy     = (state != RX_IDLE);

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state     <= RX_IDLE;
         shiftReg  <= '0;
         bitCount  <= '0;
         stopCount <= 1'b0;
         parityBad <= 1'b0;
      end else if (en) begin
         case (state)
            RX_IDLE: begin
               if (fallEdge) begin
                  state     <= RX_START;
                  bitCount  <= '0;
                  stopCount <= 1'b0;
                  parityBad <= 1'b0;
               end
            end
            RX_START: begin
               if (sampleStrobe && bitVal) state <= RX_IDLE;
               else if (wrapStrobe)        state <= RX_DATA;
            end
            RX_DATA: begin
               if (sampleStrobe) begin
                  shiftReg <= {bitVal, shiftReg[DataBits-1:1]};
                  bitCount <= bitCount + BW'(1);
               end
               if (wrapStrobe && bitCount == BW'(DataBits))
                  state <= (Parity != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
               if (sampleStrobe) parityBad <= bitVal ^ (^shiftReg) ^ (Parity == PARITY_ODD);
               if (wrapStrobe)   state <= RX_STOP;
            end
            RX_STOP: begin
               // Leave as soon as the last stop sample is good so a following start edge is not missed.
               if (sampleStrobe) begin
                  if (!bitVal)       state <= RX_ERROR;
                  else if (lastStop) state <= RX_IDLE;
                  else               stopCount <= stopCount + 1'b1;
               end
            end
            RX_ERROR: state <= RX_IDLE;
            default:  state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) frameErr <= 1'b0;
      else         frameErr <= sampleStrobe && (state == RX_STOP) && !bitVal;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         data      <= '0;
         valid     <= 1'b0;
         parityErr <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!valid || ready) begin
               data      <= shiftReg;
               parityErr <= (Parity != PARITY_NONE) && parityBad;
               valid     <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized self-checking bench for uart_rx_frame (8N1 and 7E1 instances)
module tb_uart_rx_frame;

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic       en = 1'b0;
   logic       line8 = 1'b1, line7 = 1'b1;
   logic       ready8 = 1'b1, ready7 = 1'b1;
   logic [7:0] data8;
   logic [6:0] data7;
   logic       valid8, perr8, fe8, ov8, busy8;
   logic       valid7, perr7, fe7, ov7, busy7;

   int         checks = 0;
   int         errors = 0;
   int         enDiv = 0;
   logic [7:0] last8 = 8'h00;

   int         rNValid, rFe, rOv;
   logic [8:0] rData;
   logic       rPerr;
   bit         rBusySeen;

   uart_rx_frame #(.Oversample(16), .DataBits(8), .Parity(uart_pkg::PARITY_NONE), .StopBits(1)) d8 (
      .clk(clk), .nReset(nReset), .en(en), .in(line8), .data(data8), .valid(valid8), .ready(ready8),
      .parityErr(perr8), .frameErr(fe8), .overrun(ov8), .busy(busy8));

   uart_rx_frame #(.Oversample(16), .DataBits(7), .Parity(uart_pkg::PARITY_EVEN), .StopBits(1)) d7 (
      .clk(clk), .nReset(nReset), .en(en), .in(line7), .data(data7), .valid(valid7), .ready(ready7),
      .parityErr(perr7), .frameErr(fe7), .overrun(ov7), .busy(busy7));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      enDiv = (enDiv + 1) % 4;
      en = (enDiv == 0);
   end

   task automatic tick();
      @(posedge clk);
      while (en !== 1'b1) @(posedge clk);
      #1;
   endtask

   task automatic setLine(input int which, input logic v);
      if (which == 0) line8 = v;
      else            line7 = v;
   endtask

   task automatic sendFrame(input int which, input logic [8:0] word, input bit withPar, input bit parBit,
                            input bit stopBit, input int spikeBit);
      logic bits[$];
      int   n;
      n = (which == 0) ? 8 : 7;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) bits.push_back(word[i]);
      if (withPar) bits.push_back(parBit);
      bits.push_back(stopBit);
      tick();
      for (int b = 0; b < bits.size(); b++)
         for (int t = 0; t < 16; t++) begin
            setLine(which, (b == spikeBit && t == 7) ? ~bits[b] : bits[b]);
            tick();
         end
      setLine(which, 1'b1);
      repeat (24) tick();
   endtask

   task automatic watch(input int which, input int cycles);
      logic v, pe, fe, ov, b;
      logic [8:0] d;
      rNValid = 0; rFe = 0; rOv = 0; rData = '0; rPerr = 1'b0; rBusySeen = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (which == 0) begin v = valid8; d = {1'b0, data8}; pe = perr8; fe = fe8; ov = ov8; b = busy8; end
         else begin v = valid7; d = {2'b00, data7}; pe = perr7; fe = fe7; ov = ov7; b = busy7; end
         if (v && rNValid == 0) begin rData = d; rPerr = pe; end
         if (v) rNValid++;
         if (fe) rFe++;
         if (ov) rOv++;
         if (b) rBusySeen = 1'b1;
      end
   endtask

   task automatic runFrame(input int which, input logic [8:0] word, input bit withPar, input bit parBit,
                           input bit stopBit, input int spikeBit);
      int nb;
      nb = ((which == 0) ? 8 : 7) + (withPar ? 1 : 0) + 2;
      fork
         sendFrame(which, word, withPar, parBit, stopBit, spikeBit);
         watch(which, (nb * 16 + 28) * 4);
      join
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL reset_data8: got %h want 00", data8); end
      checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", valid8); end
      checks++; if (perr8 !== 1'b0) begin errors++; $display("FAIL reset_perr8: got %b want 0", perr8); end
      checks++; if (fe8 !== 1'b0) begin errors++; $display("FAIL reset_fe8: got %b want 0", fe8); end
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8: got %b want 0", ov8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
      checks++; if (valid7 !== 1'b0 || busy7 !== 1'b0) begin errors++;
         $display("FAIL reset_d7: got valid=%b busy=%b want 0 0", valid7, busy7); end
      @(negedge clk) nReset = 1'b1;
      repeat (8) tick();
   endtask

   task automatic test_basic_8n1();
      runFrame(0, 9'h0A5, 1'b0, 1'b0, 1'b1, -1);
      checks++; if (rNValid !== 1) begin errors++; $display("FAIL a5_valid_cycles: got %0d want 1", rNValid); end
      checks++; if (rData !== 9'h0A5) begin errors++; $display("FAIL a5_data: got %h want a5", rData); end
      checks++; if (rPerr !== 1'b0) begin errors++; $display("FAIL a5_perr: got %b want 0", rPerr); end
      checks++; if (rFe !== 0) begin errors++; $display("FAIL a5_frameErr: got %0d want 0", rFe); end
      last8 = 8'hA5;
   endtask

   task automatic test_random_8n1();
      logic [7:0] w;
      for (int i = 0; i < 6; i++) begin
         w = 8'($urandom_range(0, 255));
         runFrame(0, {1'b0, w}, 1'b0, 1'b0, 1'b1, -1);
         checks++; if (rNValid !== 1 || rData !== {1'b0, w}) begin errors++;
            $display("FAIL rand8_%0d: got n=%0d data=%h want n=1 data=%h", i, rNValid, rData, w); end
         last8 = w;
      end
   endtask

   task automatic test_parity_7e1();
      logic [6:0] w;
      bit bad;
      runFrame(1, 9'h041, 1'b1, ~(^7'h41), 1'b1, -1);
      checks++; if (rData !== 9'h041) begin errors++; $display("FAIL par41_data: got %h want 41", rData); end
      checks++; if (rPerr !== 1'b1) begin errors++; $display("FAIL par41_perr: got %b want 1", rPerr); end
      for (int i = 0; i < 5; i++) begin
         w = 7'($urandom_range(0, 127));
         bad = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         runFrame(1, {2'b00, w}, 1'b1, (^w) ^ bad, 1'b1, -1);
         checks++; if (rNValid !== 1 || rData !== {2'b00, w} || rPerr !== bad) begin errors++;
            $display("FAIL par7_%0d: got n=%0d data=%h perr=%b want n=1 data=%h perr=%b",
                     i, rNValid, rData, rPerr, w, bad); end
      end
   endtask

   task automatic test_frame_error();
      logic [7:0] w;
      runFrame(0, 9'h03C, 1'b0, 1'b0, 1'b0, -1);
      checks++; if (rFe !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", rFe); end
      checks++; if (rNValid !== 0) begin errors++; $display("FAIL ferr_valid: got %0d cycles want 0", rNValid); end
      checks++; if (data8 !== last8) begin errors++; $display("FAIL ferr_data: got %h want %h", data8, last8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b want 0", busy8); end
      w = 8'($urandom_range(0, 255));
      runFrame(0, {1'b0, w}, 1'b0, 1'b0, 1'b1, -1);
      checks++; if (rNValid !== 1 || rData !== {1'b0, w}) begin errors++;
         $display("FAIL ferr_recover: got n=%0d data=%h want n=1 data=%h", rNValid, rData, w); end
      last8 = w;
   endtask

   task automatic test_overrun();
      ready8 = 1'b0;
      runFrame(0, 9'h011, 1'b0, 1'b0, 1'b1, -1);
      checks++; if (valid8 !== 1'b1 || data8 !== 8'h11) begin errors++;
         $display("FAIL ovr_first: got valid=%b data=%h want 1 11", valid8, data8); end
      runFrame(0, 9'h022, 1'b0, 1'b0, 1'b1, -1);
      checks++; if (rOv !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", rOv); end
      checks++; if (valid8 !== 1'b1 || data8 !== 8'h11) begin errors++;
         $display("FAIL ovr_held: got valid=%b data=%h want 1 11", valid8, data8); end
      ready8 = 1'b1;
      @(posedge clk); #1;
      checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL ovr_accept: got valid=%b want 0", valid8); end
      last8 = 8'h11;
   endtask

   task automatic test_glitch();
      fork
         begin tick(); setLine(0, 1'b0); tick(); setLine(0, 1'b1); end
         watch(0, 3 * 64);
      join
      checks++; if (rNValid !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", rNValid); end
      checks++; if (rBusySeen !== 1'b1) begin errors++; $display("FAIL glitch_start: got busySeen=%b want 1", rBusySeen); end
      checks++; if (busy8 !== 1'b0 || rFe !== 0) begin errors++;
         $display("FAIL glitch_idle: got busy=%b fe=%0d want 0 0", busy8, rFe); end
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_spike();
      logic [7:0] w;
      for (int i = 0; i < 3; i++) begin
         w = 8'($urandom_range(0, 255));
         runFrame(0, {1'b0, w}, 1'b0, 1'b0, 1'b1, 2 + 3 * i);
         checks++; if (rNValid !== 1 || rData !== {1'b0, w}) begin errors++;
            $display("FAIL spike_%0d: got n=%0d data=%h want n=1 data=%h", i, rNValid, rData, w); end
         last8 = w;
      end
   endtask
`endif

   task automatic test_reset_mid();
      tick();
      setLine(0, 1'b0); repeat (16) tick();
      setLine(0, 1'b1); repeat (16) tick();
      setLine(0, 1'b0); repeat (16) tick();
      setLine(0, 1'b1); repeat (8) tick();
      checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", busy8); end
      #3 nReset = 1'b0;
      #1;
      checks++; if (data8 !== 8'h00 || valid8 !== 1'b0 || busy8 !== 1'b0) begin errors++;
         $display("FAIL rst_mid_out: got data=%h valid=%b busy=%b want 00 0 0", data8, valid8, busy8); end
      checks++; if (perr8 !== 1'b0 || fe8 !== 1'b0 || ov8 !== 1'b0) begin errors++;
         $display("FAIL rst_mid_flags: got perr=%b fe=%b ov=%b want 0 0 0", perr8, fe8, ov8); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (valid8 !== 1'b0 || busy8 !== 1'b0) begin errors++;
         $display("FAIL rst_mid_hold: got valid=%b busy=%b want 0 0", valid8, busy8); end
      @(negedge clk) nReset = 1'b1;
      repeat (20) tick();
      runFrame(0, 9'h05A, 1'b0, 1'b0, 1'b1, -1);
      checks++; if (rNValid !== 1 || rData !== 9'h05A) begin errors++;
         $display("FAIL rst_mid_next: got n=%0d data=%h want n=1 data=5a", rNValid, rData); end
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_random_8n1();
      test_parity_7e1();
      test_frame_error();
      test_overrun();
      test_glitch();
`ifdef UART_RX_MAJORITY_EN
      test_spike();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
